// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: per-channel ap_ctrl handshake statistics (transactions,
// activity, stalls, latency) with a registered read port for on-chip profiling.
// Ports: clock/reset (sync, active-high), clear, finish; ap_start/ap_ready/
// ap_done/ap_continue are NUM_CH-wide, one bit per channel; rd_en/rd_ch/rd_sel
// request a read, answered one cycle later on rd_valid/rd_data/rd_err;
// glob_cycles counts unfrozen cycles; frozen is the sticky finish flag.
// Optional: define AP_PERF_MIN_LAT_EN for a per-channel min_lat register.
module ap_ctrl_perf_monitor #(
  parameter  int NUM_CH = 6,
  parameter  int CNT_W  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [CNT_W-1:0]  glob_cycles,
  output logic              frozen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } st_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CH_W:0]    NCH = NUM_CH[CH_W:0];

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && !(&v)) ? v + ONE : v;
  endfunction

  logic wipe;
  logic upd;

  assign wipe = reset | clear;
  assign upd  = ~frozen;

  // Per channel, word k holds statistic k in rd_sel order.
  logic [NUM_CH-1:0][7:0][CNT_W-1:0] stat;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    st_e              st_q;
    st_e              st_d;
    logic [CNT_W-1:0] lat_q;
    logic [CNT_W-1:0] lat_d;
    logic [CNT_W-1:0] lat_inc;
    logic [CNT_W-1:0] rec_v;
    logic             rec;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] done_q;
    logic [CNT_W-1:0] act_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] min_v;
    logic             acc;
    logic             fin;
    logic             busy;

    assign lat_inc = sat_inc(lat_q, 1'b1);
    assign acc     = ap_start[i] & ap_ready[i];
    assign fin     = ap_done[i] & ap_continue[i];
    // The IDLE cycle that sees ap_start already counts as active.
    assign busy    = (st_q != IDLE) | ap_start[i];

    always_comb begin
      st_d  = st_q;
      lat_d = lat_q;
      rec   = 1'b0;
      rec_v = lat_inc;
      unique case (st_q)
        IDLE: begin
          if (ap_start[i]) begin
            if (ap_done[i]) begin
              rec   = 1'b1;
              rec_v = ONE;
              st_d  = ap_continue[i] ? IDLE : HOLD;
            end else begin
              st_d  = RUN;
              lat_d = ONE;
            end
          end
        end
        RUN: begin
          if (ap_done[i]) begin
            rec  = 1'b1;
            st_d = ap_continue[i] ? IDLE : HOLD;
          end else begin
            lat_d = lat_inc;
          end
        end
        HOLD: begin
          if (ap_continue[i]) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (wipe) begin
        st_q  <= IDLE;
        lat_q <= '0;
      end else if (upd) begin
        st_q  <= st_d;
        lat_q <= lat_d;
      end
    end

    always_ff @(posedge clock) begin
      if (wipe) begin
        start_q <= '0;
        done_q  <= '0;
        act_q   <= '0;
        stall_q <= '0;
        last_q  <= '0;
        max_q   <= '0;
      end else if (upd) begin
        start_q <= sat_inc(start_q, acc);
        done_q  <= sat_inc(done_q, fin);
        act_q   <= sat_inc(act_q, busy);
        stall_q <= sat_inc(stall_q, st_q == HOLD);
        if (rec) begin
          last_q <= rec_v;
          if (rec_v > max_q) max_q <= rec_v;
        end
      end
    end

`ifdef AP_PERF_MIN_LAT_EN
    logic [CNT_W-1:0] min_q;

    always_ff @(posedge clock) begin
      if (wipe) begin
        min_q <= '1;
      end else if (upd && rec && (rec_v < min_q)) begin
        min_q <= rec_v;
      end
    end

    assign min_v = min_q;
`else
    assign min_v = '0;
`endif

    assign stat[i] = {
      {{(CNT_W-2){1'b0}}, st_q},
      min_v,
      max_q,
      last_q,
      stall_q,
      act_q,
      done_q,
      start_q
    };
  end

  logic [CNT_W-1:0] rd_word;
  logic             rd_oob;

  assign rd_oob = {1'b0, rd_ch} >= NCH;

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) rd_word = stat[c][rd_sel];
    end
  end

  // Read port ignores clear so a read issued alongside it still returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err  <= rd_oob;
        rd_data <= rd_oob ? '0 : rd_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wipe) begin
      glob_cycles <= '0;
      frozen      <= 1'b0;
    end else begin
      if (upd) glob_cycles <= sat_inc(glob_cycles, 1'b1);
      if (finish) frozen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor: directed + random stimulus against a
// timestamp-based reference model of the handshake statistics.
module tb_ap_ctrl_perf_monitor;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int SAT = 255;

`ifdef AP_PERF_MIN_LAT_EN
  localparam bit MINEN = 1'b1;
`else
  localparam bit MINEN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           clear;
  logic           finish;
  logic [NCH-1:0] ap_start;
  logic [NCH-1:0] ap_ready;
  logic [NCH-1:0] ap_done;
  logic [NCH-1:0] ap_continue;
  logic           rd_en;
  logic [1:0]     rd_ch;
  logic [2:0]     rd_sel;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic           rd_err;
  logic [W-1:0]   glob_cycles;
  logic           frozen;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: unbounded integers, clamped only when observed.
  int m_st    [NCH];
  int m_t0    [NCH];
  int m_start [NCH];
  int m_done  [NCH];
  int m_act   [NCH];
  int m_stall [NCH];
  int m_last  [NCH];
  int m_max   [NCH];
  int m_min   [NCH];
  int m_glob;
  int cyc = 0;
  bit m_frozen;

  ap_ctrl_perf_monitor #(
    .NUM_CH(NCH),
    .CNT_W (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .finish     (finish),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_continue(ap_continue),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch),
    .rd_sel     (rd_sel),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .glob_cycles(glob_cycles),
    .frozen     (frozen)
  );

  always #5 clock = ~clock;

  function automatic int clamp(int x);
    return (x > SAT) ? SAT : x;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c]    = 0;
      m_t0[c]    = 0;
      m_start[c] = 0;
      m_done[c]  = 0;
      m_act[c]   = 0;
      m_stall[c] = 0;
      m_last[c]  = 0;
      m_max[c]   = 0;
      m_min[c]   = SAT;
    end
    m_glob   = 0;
    m_frozen = 1'b0;
  endtask

  task automatic record(int c, int lat);
    int l;
    l = clamp(lat);
    m_last[c] = l;
    if (l > m_max[c]) m_max[c] = l;
    if (l < m_min[c]) m_min[c] = l;
  endtask

  function automatic logic [63:0] m_read(int c, int sel);
    case (sel)
      0: return 64'(clamp(m_start[c]));
      1: return 64'(clamp(m_done[c]));
      2: return 64'(clamp(m_act[c]));
      3: return 64'(clamp(m_stall[c]));
      4: return 64'(m_last[c]);
      5: return 64'(m_max[c]);
      6: return MINEN ? 64'(m_min[c]) : 64'd0;
      default: return 64'(m_st[c]);
    endcase
  endfunction

  task automatic model_update();
    bit s, r, d, k;
    if (reset || clear) begin
      m_reset();
    end else begin
      if (!m_frozen) begin
        m_glob++;
        for (int c = 0; c < NCH; c++) begin
          s = ap_start[c];
          r = ap_ready[c];
          d = ap_done[c];
          k = ap_continue[c];
          if (s && r) m_start[c]++;
          if (d && k) m_done[c]++;
          if (m_st[c] == 0) begin
            if (s) begin
              m_act[c]++;
              if (d) begin
                record(c, 1);
                m_st[c] = k ? 0 : 2;
              end else begin
                m_st[c] = 1;
                m_t0[c] = cyc;
              end
            end
          end else if (m_st[c] == 1) begin
            m_act[c]++;
            if (d) begin
              record(c, cyc - m_t0[c] + 1);
              m_st[c] = k ? 0 : 2;
            end
          end else begin
            m_act[c]++;
            m_stall[c]++;
            if (k) m_st[c] = 0;
          end
        end
      end
      if (finish) m_frozen = 1'b1;
    end
    cyc++;
  endtask

  task automatic tick();
    logic        ev;
    logic        ee;
    logic [63:0] ed;
    string       tg;
    ev = rd_en & ~reset;
    ee = ev & (rd_ch >= NCH);
    ed = (ev && !ee) ? m_read(int'(rd_ch), int'(rd_sel)) : 64'd0;
    tg = $sformatf("rd ch%0d sel%0d", rd_ch, rd_sel);
    model_update();
    @(posedge clock);
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev || reset) begin
      chk({tg, " err"}, 64'(rd_err), 64'(ee));
      chk({tg, " data"}, 64'(rd_data), ed);
    end
    chk("glob_cycles", 64'(glob_cycles), 64'(clamp(m_glob)));
    chk("frozen", 64'(frozen), 64'(m_frozen));
  endtask

  task automatic idle();
    ap_start    = '0;
    ap_ready    = '0;
    ap_done     = '0;
    ap_continue = '1;
  endtask

  task automatic rd_const(string tag, int c, int sel, logic [63:0] exp);
    rd_en  = 1'b1;
    rd_ch  = 2'(c);
    rd_sel = 3'(sel);
    tick();
    rd_en  = 1'b0;
    chk(tag, 64'(rd_data), exp);
  endtask

  task automatic rnd_ticks(int n, bit ctl);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) begin
        ap_start[c]    = ($urandom_range(0, 3) == 0);
        ap_ready[c]    = ($urandom_range(0, 1) == 0);
        ap_done[c]     = ($urandom_range(0, 1 + 5 * c) == 0);
        ap_continue[c] = ($urandom_range(0, 3) != 0);
      end
      rd_en  = ($urandom_range(0, 3) != 0);
      rd_ch  = 2'($urandom_range(0, 3));
      rd_sel = 3'($urandom_range(0, 7));
      clear  = ctl && ($urandom_range(0, 149) == 0);
      finish = ctl && ($urandom_range(0, 299) == 0);
      tick();
    end
    clear  = 1'b0;
    finish = 1'b0;
    rd_en  = 1'b0;
    idle();
  endtask

  initial begin
    m_reset();
    idle();
    reset  = 1'b1;
    clear  = 1'b0;
    finish = 1'b0;
    rd_en  = 1'b0;
    rd_ch  = '0;
    rd_sel = '0;
    tick();
    tick();
    reset = 1'b0;

    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 8; s++) begin
        rd_const("reset val", c, s,
                 (s == 6 && MINEN && c < NCH) ? 64'd255 : 64'd0);
      end
    end

    // ch0: 5-cycle transaction
    ap_start = 3'b001;
    ap_ready = 3'b001;
    tick();
    idle();
    tick();
    tick();
    tick();
    ap_done = 3'b001;
    tick();
    idle();
    rd_const("ch0 start", 0, 0, 64'd1);
    rd_const("ch0 done", 0, 1, 64'd1);
    rd_const("ch0 active", 0, 2, 64'd5);
    rd_const("ch0 last", 0, 4, 64'd5);
    rd_const("ch0 max", 0, 5, 64'd5);
    rd_const("ch0 min", 0, 6, MINEN ? 64'd5 : 64'd0);
    rd_const("ch0 state", 0, 7, 64'd0);

    // ch1: done with continue held low, 3 hold cycles
    ap_start = 3'b010;
    ap_ready = 3'b010;
    tick();
    idle();
    tick();
    tick();
    ap_done     = 3'b010;
    ap_continue = 3'b101;
    tick();
    ap_done = '0;
    rd_const("ch1 hold state", 1, 7, 64'd2);
    tick();
    ap_continue = '1;
    tick();
    rd_const("ch1 stall", 1, 3, 64'd3);
    rd_const("ch1 last", 1, 4, 64'd4);
    rd_const("ch1 state", 1, 7, 64'd0);
    rd_const("ch0 start kept", 0, 0, 64'd1);
    rd_const("ch0 last kept", 0, 4, 64'd5);

    // ch2: single-cycle block, four times
    ap_start = 3'b100;
    ap_ready = 3'b100;
    ap_done  = 3'b100;
    for (int i = 0; i < 4; i++) tick();
    idle();
    rd_const("ch2 last", 2, 4, 64'd1);
    rd_const("ch2 min", 2, 6, MINEN ? 64'd1 : 64'd0);

    // read issued together with clear still returns old data
    clear = 1'b1;
    rd_const("ch2 done inflight", 2, 1, 64'd4);
    clear = 1'b0;
    rd_const("ch2 done cleared", 2, 1, 64'd0);

    // ch0 held in RUN past saturation
    ap_start = 3'b001;
    ap_ready = 3'b001;
    tick();
    idle();
    for (int i = 0; i < 300; i++) tick();
    ap_done = 3'b001;
    tick();
    idle();
    rd_const("sat last", 0, 4, 64'd255);
    rd_const("sat max", 0, 5, 64'd255);
    rd_const("sat active", 0, 2, 64'd255);
    chk("glob sat", 64'(glob_cycles), 64'd255);

    // random traffic with occasional clear/finish
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rnd_ticks(700, 1'b1);

    // freeze: finish in cycle 50 after clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rnd_ticks(50, 1'b0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("glob at freeze", 64'(glob_cycles), 64'd51);
    rnd_ticks(30, 1'b0);
    chk("glob frozen", 64'(glob_cycles), 64'd51);
    chk("frozen set", 64'(frozen), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("frozen cleared", 64'(frozen), 64'd0);
    rd_const("clr start", 0, 0, 64'd0);
    rd_const("clr min", 1, 6, MINEN ? 64'd255 : 64'd0);

    // out-of-range channel
    rd_const("oob data", 3, 4, 64'd0);
    chk("oob err", 64'(rd_err), 64'd1);
    chk("oob valid", 64'(rd_valid), 64'd1);

    // reset mid-transaction, with a read pending
    ap_start = 3'b010;
    ap_ready = 3'b010;
    tick();
    idle();
    tick();
    reset  = 1'b1;
    rd_en  = 1'b1;
    rd_ch  = 2'd1;
    rd_sel = 3'd2;
    tick();
    reset = 1'b0;
    rd_en = 1'b0;
    chk("rst valid", 64'(rd_valid), 64'd0);
    rd_const("rst state", 1, 7, 64'd0);
    rd_const("rst active", 1, 2, 64'd0);
    rd_const("rst start", 1, 0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
